dragon_body: RTL and testbench

Consumer end of the dragon head's position/direction output. Keeps a shift-register history of head positions so body segments trail the head one grid step per move. Owns body length (grow/shrink) and detects player-on-body collision. Provides a registered per-segment readout port for the sprite renderer.

---
 rtl/dragon_body.sv | 120 ++++++++++++
 tb/tb_dragon_body.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dragon_body.sv
// dragon_body: trailing body history behind the dragon head,
// length control, player collision and per-segment readout.
module dragon_body #(
  parameter int MAX_SEG  = 8,
  parameter int INIT_LEN = 3,
  parameter int POS_W    = 8,
  localparam int SEL_W   = $clog2(MAX_SEG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] head_pos,
  input  logic [1:0]       head_dir,
  input  logic             grow,
  input  logic             shrink,
  input  logic [POS_W-1:0] player_pos,
  input  logic [SEL_W-1:0] seg_sel,
  output logic [POS_W-1:0] seg_pos,
  output logic [1:0]       seg_dir,
  output logic             seg_active,
  output logic [3:0]       body_len,
  output logic             body_hit,
  output logic             len_sat
);

  localparam logic [3:0] L_MAX  = 4'(MAX_SEG);
  localparam logic [3:0] L_INIT = 4'(INIT_LEN);
  localparam logic [3:0] L_ONE  = 4'd1;
  localparam bit SEL_FULL = (MAX_SEG == (1 << SEL_W));

  logic [POS_W-1:0] r_pos [MAX_SEG];
  logic [1:0]       r_dir [MAX_SEG];
  logic [POS_W-1:0] r_head_q;
  logic [1:0]       r_head_dir_q;
  logic [3:0]       r_len;
  logic             r_len_sat;
  logic [POS_W-1:0] r_seg_pos;
  logic [1:0]       r_seg_dir;
  logic             r_seg_active;
  logic             r_body_hit;

  logic w_move;
  logic w_sel_ok;
  logic w_hit;

  assign w_move   = (head_pos != r_head_q);
  assign w_sel_ok = SEL_FULL ? 1'b1
                  : (seg_sel < SEL_W'(MAX_SEG));

  // Overlap of player with any currently active segment.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < MAX_SEG; i++) begin
      if ((4'(i) < r_len) && (r_pos[i] == player_pos))
        w_hit = 1'b1;
    end
  end

  // Head tracking and history shift on each grid move.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head_q     <= '0;
      r_head_dir_q <= '0;
      for (int i = 0; i < MAX_SEG; i++) begin
        r_pos[i] <= '0;
        r_dir[i] <= '0;
      end
    end else begin
      r_head_q     <= head_pos;
      r_head_dir_q <= head_dir;
      if (w_move) begin
        r_pos[0] <= r_head_q;
        r_dir[0] <= r_head_dir_q;
        for (int i = 1; i < MAX_SEG; i++) begin
          r_pos[i] <= r_pos[i-1];
          r_dir[i] <= r_dir[i-1];
        end
      end
    end
  end

  // Body length with saturation at both ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_len     <= L_INIT;
      r_len_sat <= 1'b0;
    end else begin
      r_len_sat <= 1'b0;
      if (grow && !shrink) begin
        if (r_len == L_MAX) r_len_sat <= 1'b1;
        else                r_len     <= r_len + L_ONE;
      end else if (shrink && !grow) begin
        if (r_len == L_ONE) r_len_sat <= 1'b1;
        else                r_len     <= r_len - L_ONE;
      end
    end
  end

  // Registered segment readout and collision flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seg_pos    <= '0;
      r_seg_dir    <= '0;
      r_seg_active <= 1'b0;
      r_body_hit   <= 1'b0;
    end else begin
      r_seg_pos    <= w_sel_ok ? r_pos[seg_sel] : '0;
      r_seg_dir    <= w_sel_ok ? r_dir[seg_sel] : '0;
      r_seg_active <= w_sel_ok && (4'(seg_sel) < r_len);
      r_body_hit   <= w_hit;
    end
  end

  assign seg_pos    = r_seg_pos;
  assign seg_dir    = r_seg_dir;
  assign seg_active = r_seg_active;
  assign body_len   = r_len;
  assign body_hit   = r_body_hit;
  assign len_sat    = r_len_sat;

endmodule

// File: tb/tb_dragon_body.sv
// tb_dragon_body: directed plan steps plus random traffic,
// checked against a queue-based history model.
module tb_dragon_body;

  localparam int MAXS = 8;
  localparam int INIT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] head_pos;
  logic [1:0] head_dir;
  logic       grow, shrink;
  logic [7:0] player_pos;
  logic [2:0] seg_sel;
  logic [7:0] seg_pos;
  logic [1:0] seg_dir;
  logic       seg_active;
  logic [3:0] body_len;
  logic       body_hit;
  logic       len_sat;

  int ntests = 0;
  int nfail  = 0;

  // model state: history of previous head cells, newest first
  logic [7:0] m_pos[$];
  logic [1:0] m_dir[$];
  logic [7:0] m_hq;
  logic [1:0] m_hdq;
  int         m_len;

  dragon_body #(.MAX_SEG(MAXS), .INIT_LEN(INIT), .POS_W(8)) dut (
    .clk(clk), .reset(reset),
    .head_pos(head_pos), .head_dir(head_dir),
    .grow(grow), .shrink(shrink),
    .player_pos(player_pos), .seg_sel(seg_sel),
    .seg_pos(seg_pos), .seg_dir(seg_dir),
    .seg_active(seg_active), .body_len(body_len),
    .body_hit(body_hit), .len_sat(len_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos.delete();
    m_dir.delete();
    for (int i = 0; i < MAXS; i++) begin
      m_pos.push_back(8'h00);
      m_dir.push_back(2'b00);
    end
    m_hq  = 8'h00;
    m_hdq = 2'b00;
    m_len = INIT;
  endtask

  // one clock: predict, advance model, compare after the edge
  task automatic step();
    logic [7:0] e_pos;
    logic [1:0] e_dir;
    logic e_act, e_hit, e_sat;
    if (!reset) begin
      model_reset();
      e_pos = 0; e_dir = 0; e_act = 0; e_hit = 0; e_sat = 0;
    end else begin
      e_pos = m_pos[seg_sel];
      e_dir = m_dir[seg_sel];
      e_act = (int'(seg_sel) < m_len);
      e_hit = 0;
      for (int i = 0; i < m_len; i++)
        if (m_pos[i] == player_pos) e_hit = 1;
      e_sat = 0;
      if (grow && !shrink) begin
        if (m_len == MAXS) e_sat = 1;
        else m_len++;
      end else if (shrink && !grow) begin
        if (m_len == 1) e_sat = 1;
        else m_len--;
      end
      if (head_pos != m_hq) begin
        m_pos.push_front(m_hq);
        m_dir.push_front(m_hdq);
        void'(m_pos.pop_back());
        void'(m_dir.pop_back());
      end
      m_hq  = head_pos;
      m_hdq = head_dir;
    end
    @(posedge clk);
    #1;
    chk("seg_pos", 32'(seg_pos), 32'(e_pos));
    chk("seg_dir", 32'(seg_dir), 32'(e_dir));
    chk("seg_active", 32'(seg_active), 32'(e_act));
    chk("body_len", 32'(body_len), 32'(m_len));
    chk("body_hit", 32'(body_hit), 32'(e_hit));
    chk("len_sat", 32'(len_sat), 32'(e_sat));
  endtask

  task automatic pulse(logic g, logic s);
    grow = g; shrink = s;
    step();
    grow = 0; shrink = 0;
  endtask

  task automatic sweep();
    for (int s = 0; s < MAXS; s++) begin
      seg_sel = 3'(s);
      step();
    end
  endtask

  task automatic move_to(logic [7:0] p, logic [1:0] d);
    head_pos = p; head_dir = d;
    repeat (4) step();
  endtask

  initial begin
    reset = 0; head_pos = 0; head_dir = 0;
    grow = 0; shrink = 0; player_pos = 8'hFF; seg_sel = 0;
    model_reset();
    // plan 1: reset state and readout
    step(); step();
    chk("rst_len", 32'(body_len), 32'(INIT));
    reset = 1;
    sweep();
    // plan 2: head walk
    move_to(8'h10, 2'b01);
    move_to(8'h20, 2'b01);
    move_to(8'h21, 2'b10);
    seg_sel = 0; step();
    chk("p2_sel0_pos", 32'(seg_pos), 32'h20);
    chk("p2_sel0_dir", 32'(seg_dir), 32'h1);
    sweep();
    // plan 3: grow then move
    pulse(1, 0);
    move_to(8'h22, 2'b10);
    sweep();
    chk("p3_len", 32'(body_len), 32'd4);
    // plan 4: saturation both ways
    repeat (6) pulse(1, 0);
    chk("p4_len_max", 32'(body_len), 32'd8);
    repeat (8) pulse(0, 1);
    chk("p4_len_min", 32'(body_len), 32'd1);
    pulse(1, 1);
    pulse(1, 0); pulse(1, 0);
    pulse(1, 1);
    chk("p4_len_gs", 32'(body_len), 32'd3);
    // plan 5: collision on entry1 then shrink away
    player_pos = m_pos[1];
    step(); step();
    chk("p5_hit", 32'(body_hit), 32'd1);
    pulse(0, 1); pulse(0, 1);
    step(); step();
    chk("p5_nohit", 32'(body_hit), 32'd0);
    // plan 6: reset alongside move and grow
    head_pos = 8'h55; grow = 1; reset = 0;
    step();
    grow = 0; reset = 1; head_pos = 8'h00; head_dir = 0;
    sweep();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 2) == 0) head_pos = 8'($urandom);
      head_dir = 2'($urandom);
      grow   = ($urandom_range(0, 4) == 0);
      shrink = ($urandom_range(0, 4) == 0);
      seg_sel = 3'($urandom);
      if ($urandom_range(0, 1) == 0)
        player_pos = m_pos[$urandom_range(0, MAXS-1)];
      else
        player_pos = 8'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
